// File: rtl/pmod_als_spi_receiver_if.sv
// pmod_als_spi_receiver_if: SPI pins plus request/result signals of the PMOD ALS reader
interface pmod_als_spi_receiver_if;
  logic       req;
  logic       sdo;
  logic       cs;
  logic       sck;
  logic       busy;
  logic       valid;
  logic [7:0] value;
  logic       fmt_err;
  modport master (input req, sdo, output cs, sck, busy, valid, value, fmt_err);
  modport slave (output req, sdo, input cs, sck, busy, valid, value, fmt_err);
endinterface

// File: rtl/pmod_als_spi_receiver.sv
// pmod_als_spi_receiver: SPI master reading the 8-bit light value from a PMOD ALS sensor
module pmod_als_spi_receiver #(
  parameter int CLK_DIV_HALF = 4,
  parameter int GAP_SCK      = 2,
  parameter bit AUTO         = 1'b0
) (
  input logic                       clock,
  input logic                       reset_n,
  pmod_als_spi_receiver_if.master   bus
);
  localparam int DW = CLK_DIV_HALF > 1 ? $clog2(CLK_DIV_HALF) : 1;
  localparam int GW = GAP_SCK > 1 ? $clog2(GAP_SCK) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [3:0]    bit_q;
  logic [15:0]   shift_q;
  logic [7:0]    value_q;
  logic          sck_q, cs_q, pend_q, cap_q, valid_q, fmt_q;
  logic          tick, rise;
  assign tick = div_q == DW'(CLK_DIV_HALF - 1);
  assign rise = tick && !sck_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      value_q <= '0;
      sck_q   <= 1'b1;
      cs_q    <= 1'b1;
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
      valid_q <= 1'b0;
      fmt_q   <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      sck_q   <= tick ? !sck_q : sck_q;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // a request is remembered until the next rising sck so cs always falls with sck high
          if (bus.req) pend_q <= 1'b1;
          if (rise && (pend_q || bus.req || AUTO)) begin
            cs_q    <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: if (rise) begin
          shift_q <= {shift_q[14:0], bus.sdo};
          bit_q   <= bit_q + 1'b1;
          if (bit_q == 4'd15) begin
            cs_q    <= 1'b1;
            cap_q   <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cap_q) begin
            cap_q   <= 1'b0;
            valid_q <= 1'b1;
            value_q <= shift_q[11:4];
            fmt_q   <= (shift_q[15:12] != 4'd0) || (shift_q[3:0] != 4'd0);
          end
          if (rise) begin
            gap_q <= gap_q + 1'b1;
            if (gap_q == GW'(GAP_SCK - 1)) begin
              gap_q   <= '0;
              cs_q    <= !AUTO;
              state_q <= AUTO ? SHIFT : IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cs      = cs_q;
  assign bus.sck     = sck_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.valid   = valid_q;
  assign bus.value   = value_q;
  assign bus.fmt_err = fmt_q;
endmodule

// File: doc/pmod_als_spi_receiver.md
Name: pmod_als_spi_receiver

Overview:
SPI master that reads the 8-bit light value from the PMOD ALS ambient light sensor.
- Drives cs/sck and samples sdo from the sensor; on the simulation bench the sensor is the ALS SPI stub.
- Outputs a registered 8-bit value to the peripheral register read by the core.
- Sits in mfp_system between the SPI pins and the AHB-Lite GPIO/peripheral read mux.

Parameters:
CLK_DIV_HALF, 4, clock cycles per sck half-period; minimum 1.
GAP_SCK, 2, sck periods with cs high between frames; minimum 1, so the sensor reloads on a falling edge.
AUTO, 0, 1 = back-to-back frames without req.

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous, active-low reset
req  input  1  one-cycle conversion request; only sampled in IDLE
sdo  input  1  serial data from the sensor
cs  output  1  chip select, active low
sck  output  1  serial clock; free-running, idles high after reset
busy  output  1  high in any state other than IDLE
valid  output  1  one-cycle pulse; value and fmt_err are updated in this cycle
value  output  8  last captured light value (frame bits 11:4)
fmt_err  output  1  last frame had a nonzero bit in 15:12 or 3:0

Behaviour:
Reset (reset_n low at a clock edge, honoured even mid-frame):
- cs=1, sck=1, divider=0, bit counter=0, state IDLE.
- busy=0, valid=0, value=8'h00, fmt_err=0, shift register cleared.

sck generation:
- Divider counts 0..CLK_DIV_HALF-1; at terminal count sck toggles and the divider wraps.
- rise_evt = the cycle where sck goes 0->1; fall_evt = the cycle where sck goes 1->0.
- sck toggles in all states, including IDLE.

States:
- IDLE: cs=1. Leave for SHIFT when req, or AUTO=1, is seen before a rise_evt. At that rise_evt, cs<=0 on the same edge sck goes high.
- SHIFT:
  - The sensor drives each new bit on the sck falling edge; the master samples sdo at each rise_evt: shift <= {shift[14:0], sdo}, bitcnt++.
  - At the 16th sample (bitcnt==15 before the increment), cs<=1 and go to GAP.
  - Bit 15 is sampled at the first rise_evt after the cs fall, not at the cs-fall edge itself.
- GAP:
  - On the first clock after entering GAP: valid<=1 for one cycle, value<=shift[11:4], fmt_err<=(shift[15:12]!=0)||(shift[3:0]!=0).
  - Count GAP_SCK rise_evts. At the last one: if AUTO=1, cs<=0 on that edge and enter SHIFT; otherwise enter IDLE.

Timing (E0 = cs-fall edge, CLK_DIV_HALF=4):
- 16th sample at E0+128.
- valid at E0+129.
- GAP_SCK=2: IDLE, or AUTO restart, at E0+144. AUTO frame period = 8*(16+GAP_SCK) clocks = 144.

Boundary conditions:
- req while busy: ignored, not queued.
- req on the same cycle as a rise_evt in IDLE: that edge starts the frame (cs falls on it).
- value holds its previous content until the next valid; fmt_err does not block the value update.
- Reset during SHIFT: frame aborted, cs=1 next cycle, no valid.
- After reset, the first frame may start only after at least one fall_evt with cs high. Guaranteed because reset sets sck=1 and IDLE waits for a rise_evt.

Test Plan:
1. Stub value 8'hAB, CLK_DIV_HALF=4, one req pulse in IDLE:
   - cs low for exactly 128 clocks with 16 sck rises.
   - valid pulses once, 129 clocks after the cs fall.
   - value=8'hAB, fmt_err=0, busy drops at E0+144.
2. Stub value 8'h00, then 8'hFF (two runs):
   - value=00 then FF; fmt_err=0 in both.
3. AUTO=1, stub 8'h5A:
   - valid every 144 clocks, value=5A each frame.
   - cs high for exactly 16 clocks between frames; no req needed.
4. req pulsed 3 times during SHIFT:
   - Exactly one frame and one valid.
   - Next req after busy=0 starts a second frame.
5. Stub packet forced to 16'h1AB0:
   - value=8'hAB, fmt_err=1.
   - Next frame with a normal packet clears fmt_err to 0.
6. reset_n low for 1 cycle at clock E0+60 mid-SHIFT:
   - Next cycle: cs=1, sck=1, busy=0, value=00, no valid.
   - Following req completes a normal frame with value=8'hAB.
